digit_scan_ctrl: RTL and testbench



---
 rtl/digit_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_digit_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner: steps a binary digit index through the enabled digits,
// blanking the decoder enable at the start of every slot to suppress ghosting.
module digit_scan_ctrl #(
  parameter int unsigned N      = 3,
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned BLANK  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [DIGITS-1:0]     digit_mask,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [N-1:0]          sel,
  output logic                  sel_en,
  output logic [3:0]            digit_out,
  output logic                  tick
);

  localparam int unsigned     NumIdx    = 1 << N;
  localparam int unsigned     CntW      = $clog2(DIV);
  localparam logic [CntW-1:0] SlotLast  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK == 0) ? 0 : BLANK - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StShow  = 2'd2;
  localparam logic [1:0] StEntry = (BLANK == 0) ? StShow : StBlank;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]      sel_q, sel_d;
  logic              sel_en_q, sel_en_d;
  logic              tick_q, tick_d;
  logic [NumIdx-1:0] mask_ext;

  // Zero-extended so any N-bit index is in range; unused indices are never enabled.
  assign mask_ext = NumIdx'(digit_mask);

  // First enabled index at or after start (or strictly after it), wrapping at DIGITS.
  function automatic logic [N-1:0] scan_from(input logic [N-1:0]      start,
                                             input logic [NumIdx-1:0] mask,
                                             input logic              skip_start);
    logic [N-1:0] res;
    logic [N-1:0] idx;
    logic         found;
    int unsigned  pos;
    res   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      pos = (32'(start) + k + 32'(skip_start)) % DIGITS;
      idx = N'(pos);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    sel_en_d = 1'b0;
    tick_d   = 1'b0;
    if (!run || (digit_mask == '0)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d  = StEntry;
          cnt_d    = '0;
          sel_d    = scan_from(sel_q, mask_ext, 1'b0);
          sel_en_d = (BLANK == 0) && mask_ext[sel_d];
        end
        StBlank, StShow: begin
          if (cnt_q == SlotLast) begin
            state_d  = StEntry;
            cnt_d    = '0;
            tick_d   = 1'b1;
            sel_d    = scan_from(sel_q, mask_ext, 1'b1);
            sel_en_d = (BLANK == 0) && mask_ext[sel_d];
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if (state_q == StBlank) begin
              if (cnt_q == BlankLast) begin
                state_d  = StShow;
                sel_en_d = mask_ext[sel_q];
              end
            end else begin
              // Once the digit is masked off mid-slot it stays dark until the slot ends.
              sel_en_d = sel_en_q & mask_ext[sel_q];
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      sel_en_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sel_en_q <= sel_en_d;
      tick_q   <= tick_d;
    end
  end

  logic [3:0] nib [NumIdx];

  for (genvar i = 0; i < NumIdx; i++) begin : g_nib
    if (i < DIGITS) begin : g_used
      assign nib[i] = data_in[4*i +: 4];
    end else begin : g_pad
      assign nib[i] = 4'h0;
    end
  end

  assign sel       = sel_q;
  assign sel_en    = sel_en_q;
  assign tick      = tick_q;
  assign digit_out = nib[sel_q];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a slot-position reference model queues the expected
// outputs for every cycle and an independent monitor pops and compares them.
module tb_digit_scan_ctrl;

  localparam int N      = 2;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  digit_mask;
  logic [15:0] data_in;
  logic [1:0]  sel;
  logic        sel_en;
  logic        tick;
  logic [3:0]  digit_out;

  digit_scan_ctrl #(
    .N      (N),
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .digit_mask (digit_mask),
    .data_in    (data_in),
    .sel        (sel),
    .sel_en     (sel_en),
    .digit_out  (digit_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       tick;
    logic [3:0] dout;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: whether scanning, which digit, position within its slot, and whether
  // the digit has stayed enabled throughout the visible part of the slot.
  bit m_active = 1'b0;
  int m_sel    = 0;
  int m_pos    = 0;
  bit m_tick   = 1'b0;
  bit m_ok     = 1'b0;

  function automatic int first_enabled(int start, logic [3:0] mask, int offset);
    int idx;
    for (int k = 0; k < DIGITS; k++) begin
      idx = (start + offset + k) % DIGITS;
      if (mask[idx[1:0]]) return idx;
    end
    return start;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_active = 1'b0;
      m_sel    = 0;
      m_pos    = 0;
      m_tick   = 1'b0;
      m_ok     = 1'b0;
    end else if (!run || digit_mask == 4'b0000) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_tick   = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_tick   = 1'b0;
        m_sel    = first_enabled(m_sel, digit_mask, 0);
        m_ok     = 1'b1;
      end else if (m_pos == DIV - 1) begin
        m_pos  = 0;
        m_tick = 1'b1;
        m_sel  = first_enabled(m_sel, digit_mask, 1);
        m_ok   = 1'b1;
      end else begin
        m_pos  = m_pos + 1;
        m_tick = 1'b0;
      end
      if (m_pos >= BLANK) m_ok = m_ok && digit_mask[m_sel[1:0]];
    end
  endtask

  // Apply current inputs for one clock; expected post-edge outputs go to the scoreboard.
  task automatic cycle();
    obs_t e;
    model_step();
    e.sel  = m_sel[1:0];
    e.en   = m_active && (m_pos >= BLANK) && m_ok;
    e.tick = m_tick;
    e.dout = data_in[m_sel*4 +: 4];
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Advance until the model sits at digit want_sel, slot position want_pos (bounded).
  task automatic wait_until(int want_sel, int want_pos, string name);
    int budget;
    budget = 0;
    while (!(m_active && m_sel == want_sel && m_pos == want_pos) && budget < 40) begin
      cycle();
      budget++;
    end
    if (!(m_active && m_sel == want_sel && m_pos == want_pos)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: target sel=%0d pos=%0d not reached in 40 cycles", name, want_sel,
               want_pos);
    end
  endtask

  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      got = {sel, sel_en, tick, digit_out};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty at %0t: got sel=%0d en=%0b tick=%0b dout=%h", $time,
                 got.sel, got.en, got.tick, got.dout);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL cycle_check at %0t: got sel=%0d en=%0b tick=%0b dout=%h, required sel=%0d en=%0b tick=%0b dout=%h",
                   $time, got.sel, got.en, got.tick, got.dout, e.sel, e.en, e.tick, e.dout);
        end
      end
    end
  end

  initial begin : driver
    reset      = 1'b1;
    run        = 1'b1;
    digit_mask = 4'b1111;
    data_in    = 16'h4321;

    // 1: reset held, then full scan over all four digits
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_sel", int'(sel), 0);
      chk("reset_en", int'(sel_en), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_dout", int'(digit_out), 1);
    end
    reset = 1'b0;
    cycles(20);

    // 2: alternate digits only
    digit_mask = 4'b1010;
    cycles(16);

    // 3: nothing enabled, then a single digit
    digit_mask = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("mask0_en", int'(sel_en), 0);
    end
    digit_mask = 4'b0100;
    cycle();
    chk("single_entry_sel", int'(sel), 2);
    chk("single_entry_en", int'(sel_en), 0);
    cycles(12);

    // 4: run dropped mid-SHOW, then resumed
    wait_until(2, 2, "find_show_sel2");
    run = 1'b0;
    cycle();
    chk("stop_en", int'(sel_en), 0);
    chk("stop_sel", int'(sel), 2);
    chk("stop_tick", int'(tick), 0);
    cycles(4);
    run        = 1'b1;
    digit_mask = 4'b1111;
    cycles(9);

    // 5: reset pulse mid-SHOW
    wait_until(3, 2, "find_show_sel3");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_pulse_sel", int'(sel), 0);
    chk("rst_pulse_en", int'(sel_en), 0);
    chk("rst_pulse_tick", int'(tick), 0);
    cycles(8);

    // 6: current digit masked off mid-slot
    wait_until(1, 1, "find_first_show_sel1");
    digit_mask = 4'b1101;
    cycle();
    chk("drop_en_a", int'(sel_en), 0);
    cycle();
    chk("drop_en_b", int'(sel_en), 0);
    cycle();
    chk("drop_next_sel", int'(sel), 2);
    chk("drop_next_tick", int'(tick), 1);
    cycles(6);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      run     = ($urandom_range(0, 19) != 0);
      reset   = ($urandom_range(0, 99) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) digit_mask = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
